// File: rtl/seq_pulse_width_meter.sv
// seq_pulse_width_meter: registered rise/fall flags and high-pulse width measurement of a 1-bit waveform.
// Latency: fall and meas_val assert together, one cycle after the posedge sampling the falling edge.
// Backpressure: one-entry valid/ready buffer; completions while full are dropped (sticky overrun). PULSE_GLITCH_FILTER_EN drops width-1 pulses.
module seq_pulse_width_meter #(
   parameter int WIDTH_W = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               din,
   output logic               rise,
   output logic               fall,
   output logic               meas_val,
   input  logic               meas_rdy,
   output logic [WIDTH_W-1:0] meas_width,
   output logic               meas_sat,
   output logic               overrun
);

   typedef enum logic [1:0] {
      WAIT_LOW = 2'd0,
      ARMED    = 2'd1,
      COUNT    = 2'd2
   } state_t;

   localparam logic [WIDTH_W-1:0] CNT_MAX = '1;

   state_t             state;
   state_t             state_nxt;
   logic               din_q;
   logic [WIDTH_W-1:0] cnt;
   logic               cnt_sat;
   logic               start;
   logic               done;
   logic               keep;
   logic               deq;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= WAIT_LOW;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_LOW: if (!din)          state_nxt = ARMED;
         ARMED:    if (din && !din_q) state_nxt = COUNT;
         COUNT:    if (!din)          state_nxt = ARMED;
         default:                     state_nxt = WAIT_LOW;
      endcase
   end

   always_comb begin
      start = (state == ARMED) && din && !din_q;
      done  = (state == COUNT) && !din;
`ifdef PULSE_GLITCH_FILTER_EN
      keep  = done && (cnt != WIDTH_W'(1));
`else
      keep  = done;
`endif
      deq   = meas_val && meas_rdy;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         din_q <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         din_q <= din;
         rise  <= din & ~din_q;
         fall  <= ~din & din_q;
      end
   end

   // Saturation flags a pulse longer than the counter can represent; an exact max-width pulse is not saturated.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         cnt_sat <= 1'b0;
      end else if (start) begin
         cnt     <= WIDTH_W'(1);
         cnt_sat <= 1'b0;
      end else if ((state == COUNT) && din) begin
         if (cnt == CNT_MAX) begin
            cnt_sat <= 1'b1;
         end else begin
            cnt <= cnt + WIDTH_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meas_val   <= 1'b0;
         meas_width <= '0;
         meas_sat   <= 1'b0;
         overrun    <= 1'b0;
      end else if (keep) begin
         if (!meas_val || deq) begin
            meas_val   <= 1'b1;
            meas_width <= cnt;
            meas_sat   <= cnt_sat;
         end else begin
            overrun <= 1'b1;
         end
      end else if (deq) begin
         meas_val <= 1'b0;
      end
   end

endmodule

// File: doc/seq_pulse_width_meter.md
Name: seq_pulse_width_meter

Overview:
- Downstream consumer of the registered 1-bit waveform stages (e.g. a registered-inverter output).
- Samples the waveform and flags rising and falling edges with one-cycle pulses.
- Measures each high pulse's width in clock cycles and presents it through a one-entry valid/ready output buffer.
- Lets a checker or scoreboard stage read pulse widths without tracking the waveform cycle by cycle.

Parameters:
- WIDTH_W, 8, width of the pulse counter and of `meas_width`. Legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- din  input  1  waveform from the upstream registered stage.
- rise  output  1  one-cycle pulse: rising edge sampled.
- fall  output  1  one-cycle pulse: falling edge sampled.
- meas_val  output  1  buffer holds a valid measurement.
- meas_rdy  input  1  consumer accepts the measurement.
- meas_width  output  WIDTH_W  measured high-pulse width in cycles.
- meas_sat  output  1  the held measurement saturated.
- overrun  output  1  sticky: a completed measurement was dropped.

Behaviour:
- Reset (reset_n=0, takes effect immediately, asynchronous):
  - All outputs 0; `din_q`=0; counter=0; buffer empty; FSM=WAIT_LOW.
  - Reset mid-pulse discards the partial pulse; no measurement is emitted for it.
- Sampling:
  - Every posedge: `din_q` <= `din`.
  - Every posedge: `rise` <= `din` & ~`din_q`; `fall` <= ~`din` & `din_q`.
  - Both edge outputs are registered, so each is high for the one cycle after the posedge at which the edge was sampled.
- Width definition: the number of consecutive posedges at which `din` is sampled 1.
- FSM:
  - WAIT_LOW: entered at reset. If `din` is already high at reset release, that pulse is not measured. Sampled `din`=0 -> ARMED.
  - ARMED: sampled `din`=1 & `din_q`=0 -> COUNT, counter <= 1, sat <= 0.
  - COUNT, sampled `din`=1: counter <= counter+1.
    - The counter saturates at 2^WIDTH_W-1; on saturation sat <= 1 and the counter holds.
  - COUNT, sampled `din`=0: the measurement completes (width=counter, sat flag) -> ARMED.
  - A new rise on the very next posedge is accepted from ARMED, so back-to-back pulses separated by one low cycle are each measured.
- Output buffer (one entry):
  - A completed measurement loads `meas_width`/`meas_sat` at the completing posedge; `meas_val`=1 from the next cycle.
  - Dequeue occurs at a posedge with `meas_val`=1 & `meas_rdy`=1.
  - Dequeue with no new completion on the same edge: `meas_val` -> 0.
  - Dequeue and completion on the same edge: the new value loads and `meas_val` stays 1. No overrun.
  - Completion while the buffer is full and not dequeued: the new measurement is dropped, the buffer is unchanged, `overrun` <= 1. `overrun` stays set until reset.
  - `meas_width`/`meas_sat` are stable while `meas_val`=1 & `meas_rdy`=0.
  - `meas_rdy` is ignored when `meas_val`=0.
- Latency: `fall` and `meas_val` both rise one cycle after the posedge that samples the falling edge.

Optional Feature:
- Macro: PULSE_GLITCH_FILTER_EN.
- Defined: completed pulses of width 1 are discarded. No buffer load, no `overrun` effect, FSM returns to ARMED. `rise`/`fall` still pulse.
- Undefined: width-1 pulses are measured like any other (`meas_width`=1).
- Ports and all other behaviour are identical in both builds.

Test Plan:
- Reset with `din`=0, `meas_rdy`=1; `din` high for exactly 5 posedges, then low -> `rise` one cycle; 5 cycles later `fall`=1 and `meas_val`=1 with `meas_width`=5, `meas_sat`=0, both in the same cycle; `meas_val`=0 the following cycle.
- WIDTH_W=3; `din` high for 10 posedges -> `meas_width`=7, `meas_sat`=1.
- `meas_rdy`=0; pulse widths 3 then 4 -> buffer holds 3, `overrun`=1, `meas_width` stays 3. Raise `meas_rdy` -> 3 dequeued, `meas_val`=0, `overrun` stays 1.
- Pulse of 2 with `meas_rdy`=0, then `meas_rdy`=1 asserted exactly on the posedge where pulse of 6 completes -> 2 dequeued, then 6 presented, `meas_val` continuous, `overrun`=0.
- `din`=1 at reset release for 4 cycles, then low 1, high 3 -> only width 3 reported. Separately, assert reset_n=0 mid-pulse -> all outputs 0 immediately, no measurement for that pulse.
- `din` pattern high 1, low 1, high 2 -> without the macro widths 1 then 2; with PULSE_GLITCH_FILTER_EN only 2; `rise`/`fall` count 2 each in both builds.
